// File: rtl/alu_result_stage.sv
// Result stage after rca_32: captures adder results with NZCV flags into a small FIFO and keeps op/overflow counters.
// Optional feature: define STICKY_OF_EN to enable the of_sticky overflow flag (otherwise it is tied low).
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_s,
    input  logic             in_c32,
    input  logic             in_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] of_count,
    input  logic             clr_sticky,
    output logic             of_sticky
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = 36;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_last_result;
    logic [3:0]       r_last_flags;
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_of_count;

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_pop;
    logic [3:0]       w_flags;
    logic [ENT_W-1:0] w_head;

    // Full/empty come only from registered pointers, so in_ready never depends on out_ready.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_accept = in_valid & ~w_full;
    assign w_pop    = ~w_empty & out_ready;

    assign w_flags  = {in_s[31], (in_s == 32'd0), in_c32, in_of};
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_flags, in_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Holds the most recently popped entry so the outputs stay put while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_result <= '0;
            r_last_flags  <= '0;
        end else if (w_pop) begin
            r_last_result <= w_head[31:0];
            r_last_flags  <= w_head[35:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
            r_of_count <= '0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + CNT_W'(1);
            if (in_of && (r_of_count != {CNT_W{1'b1}})) begin
                r_of_count <= r_of_count + CNT_W'(1);
            end
        end
    end

`ifdef STICKY_OF_EN
    logic r_of_sticky;

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_of_sticky <= 1'b0;
        end else if (w_accept && in_of) begin
            r_of_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_of_sticky <= 1'b0;
        end
    end

    assign of_sticky = r_of_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_sticky;
    assign of_sticky    = 1'b0;
`endif

    assign in_ready   = ~w_full;
    assign out_valid  = ~w_empty;
    assign out_result = w_empty ? r_last_result : w_head[31:0];
    assign out_flags  = w_empty ? r_last_flags  : w_head[35:32];
    assign op_count   = r_op_count;
    assign of_count   = r_of_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
`ifdef STICKY_OF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_s;
    logic             in_c32;
    logic             in_of;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] of_count;
    logic             clr_sticky;
    logic             of_sticky;

    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_c32     (in_c32),
        .in_of      (in_of),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .op_count   (op_count),
        .of_count   (of_count),
        .clr_sticky (clr_sticky),
        .of_sticky  (of_sticky)
    );

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_last_r;
    logic [3:0]  m_last_f;
    int          m_op;
    int          m_of;
    logic        m_st;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [3:0] exp_flags(logic [31:0] s, logic c, logic o);
        return {s[31], (s == 32'd0), c, o};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_r = '0;
        m_last_f = '0;
        m_op     = 0;
        m_of     = 0;
        m_st     = 1'b0;
    endtask

    task automatic check_outputs(string tag);
        logic        ev;
        logic [31:0] er;
        logic [3:0]  ef;
        ev = (q.size() > 0);
        er = ev ? q[0].r : m_last_r;
        ef = ev ? q[0].f : m_last_f;
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".result"},    out_result,     er);
        chk({tag, ".flags"},     32'(out_flags), 32'(ef));
        chk({tag, ".op_count"},  32'(op_count),  32'(m_op % (1 << CNT_W)));
        chk({tag, ".of_count"},  32'(of_count),  32'(m_of));
        chk({tag, ".of_sticky"}, 32'(of_sticky), 32'(m_st));
    endtask

    // Called at a falling edge; drives one cycle, checks, and returns at the next falling edge.
    task automatic cycle(string tag, logic v, logic [31:0] s, logic c, logic o, logic rdy, logic clr);
        logic acc;
        logic pop;
        ent_t e;
        in_valid   = v;
        in_s       = s;
        in_c32     = c;
        in_of      = o;
        out_ready  = rdy;
        clr_sticky = clr;
        #1;
        check_outputs(tag);
        acc = v && (q.size() < DEPTH);
        pop = rdy && (q.size() > 0);
        @(posedge clk);
        if (pop) begin
            e = q.pop_front();
            m_last_r = e.r;
            m_last_f = e.f;
        end
        if (acc) begin
            e.r = s;
            e.f = exp_flags(s, c, o);
            q.push_back(e);
            m_op++;
            if (o && m_of < (1 << CNT_W) - 1) m_of++;
        end
        if (STICKY && acc && o) m_st = 1'b1;
        else if (STICKY && clr) m_st = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rs;
        int          mode;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_s       = '0;
        in_c32     = 1'b0;
        in_of      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle("reset_state", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Add overflow: 7FFF_FFFF + 1
        cycle("add_of", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("add_of.result_const", out_result, 32'h8000_0000);
        chk("add_of.flags_const", 32'(out_flags), 32'h9);
        chk("add_of.of_count_const", 32'(of_count), 32'd1);
        chk("add_of.op_count_const", 32'(op_count), 32'd1);
        chk("add_of.sticky_const", 32'(of_sticky), 32'(STICKY));
        cycle("add_of_pop", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Subtractions
        cycle("sub_3m1", 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sub_3m1.flags_const", 32'(out_flags), 32'h2);
        cycle("sub_zero", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sub_zero.flags_const", 32'(out_flags), 32'h6);
        cycle("sub_0m1", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sub_0m1.flags_const", 32'(out_flags), 32'h8);
        cycle("sub_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_hold.result_const", out_result, 32'hFFFF_FFFF);

        // Sticky overflow: set, set-vs-clear collision, clear
        cycle("sticky_set", 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sticky_set.const", 32'(of_sticky), 32'(STICKY));
        cycle("sticky_both", 1'b1, 32'h8000_0002, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("sticky_both.const", 32'(of_sticky), 32'(STICKY));
        cycle("sticky_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr.const", 32'(of_sticky), 32'd0);

        // Backpressure: third push is ignored, order preserved on release
        cycle("bp_push0", 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("bp_push1", 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_full.in_ready_const", 32'(in_ready), 32'd0);
        cycle("bp_push2", 1'b1, 32'hCCCC_0003, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("bp_stall", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_stall.head_const", out_result, 32'hAAAA_0001);
        cycle("bp_pop0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_pop0.head_const", out_result, 32'hBBBB_0002);
        cycle("bp_pop1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("bp_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_empty.valid_const", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries queued
        cycle("rst_q0", 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("rst_q1", 1'b1, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        chk("async_rst.op_count", 32'(op_count), 32'd0);
        chk("async_rst.of_count", 32'(of_count), 32'd0);
        chk("async_rst.result", out_result, 32'd0);
        chk("async_rst.flags", 32'(out_flags), 32'd0);
        chk("async_rst.sticky", 32'(of_sticky), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Counter wrap/saturation with 4-bit counters
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle("sat", 1'b1, $urandom, 1'($urandom), 1'b1, 1'b1, 1'b0);
        end
        chk("sat.op_count_const", 32'(op_count), 32'h4);
        chk("sat.of_count_const", 32'(of_count), 32'hF);
        cycle("sat_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 200; i++) begin
            mode = int'($urandom_range(0, 9));
            rs = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
            cycle("rand", 1'($urandom), rs, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        cycle("rand_end", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
